// File: rtl/updown_step_controller.sv
// -----------------------------------------------------------------------------
// updown_step_controller
//
// Sequencing controller for the up/down Mealy display decoder. It synchronises
// and debounces the raw Up/Down pushbuttons and arbitrates between them. It
// owns the 4-bit state register the decoder reads. For each accepted press it
// emits exactly one strobe cycle, aligned with the pre-update state.
//
// States 0..MAX_STATE form a ring. State 15 is the error state.
//
// Optional build macro:
//   UPDOWN_AUTO_REPEAT_EN - while exactly one debounced button stays high,
//                           re-issue that request every REPEAT_CYCLES cycles.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   Up_btn    in   raw asynchronous Up pushbutton, active high
//   Down_btn  in   raw asynchronous Down pushbutton, active high
//   Clear     in   synchronous soft reset, active high
//   Up        out  one-cycle Up strobe to decoder
//   Down      out  one-cycle Down strobe to decoder
//   state     out  current state (4 bits)
//   wrap      out  high in a strobe cycle whose step wraps MAX_STATE<->0
//   error     out  registered, high while state == 15
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | waiting for a request
//   ST_STROBE | one cycle: drive Up/Down with old state, commit next state
// -----------------------------------------------------------------------------
module updown_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_STATE       = 8
`ifdef UPDOWN_AUTO_REPEAT_EN
    , parameter int REPEAT_CYCLES = 16
`endif
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Up_btn,
    input  logic       Down_btn,
    input  logic       Clear,
    output logic       Up,
    output logic       Down,
    output logic [3:0] state,
    output logic       wrap,
    output logic       error
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MAX_S   = 4'(MAX_STATE);
    localparam logic [3:0] ERR_S   = 4'hF;

    typedef enum logic {ST_IDLE, ST_STROBE} fsm_t;

    // Bit 0 = Up button, bit 1 = Down button throughout.
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0] lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
    logic [7:0] db_cnt_q [2];
    logic [7:0] db_cnt_d [2];
    logic [1:0] rep_req;
    logic [1:0] req;

    fsm_t       fsm_q, fsm_d;
    logic [1:0] dir_q, dir_d;
    logic [3:0] state_q, state_d;
    logic       error_q, error_d;
    logic [3:0] eff_state;
    logic [3:0] nxt_state;
    logic       wrap_c;
    logic       strobe;

    // Synchronisers and debounce. The counter counts consecutive samples that
    // disagree with the debounced level. When it hits the limit, the level flips.
    always_comb begin
        sync1_d    = {Down_btn, Up_btn};
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        lvl_prev_d = lvl_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam logic [7:0] REP_LOAD = 8'(REPEAT_CYCLES - 1);

    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       one_held;

    // The counter reloads in every strobe cycle and counts down in IDLE. It
    // requests when it reaches 1, so the next strobe lands REPEAT_CYCLES after
    // the previous one. Zero means disarmed.
    always_comb begin
        one_held  = lvl_q[0] ^ lvl_q[1];
        rep_cnt_d = '0;
        if (!Clear && one_held) begin
            if (fsm_q == ST_STROBE) begin
                rep_cnt_d = REP_LOAD;
            end else if (rep_cnt_q != 8'd0) begin
                rep_cnt_d = rep_cnt_q - 8'd1;
            end
        end
        rep_req = (one_held && rep_cnt_q == 8'd1) ? lvl_q : 2'b00;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) rep_cnt_q <= '0;
        else          rep_cnt_q <= rep_cnt_d;
    end
`else
    assign rep_req = 2'b00;
`endif

    assign req = (lvl_q & ~lvl_prev_q) | rep_req;

    // Out-of-ring values are folded onto the error state before stepping.
    always_comb begin
        eff_state = (state_q > MAX_S) ? ERR_S : state_q;
        nxt_state = eff_state;
        wrap_c    = 1'b0;
        if (dir_q == 2'b11) begin
            nxt_state = ERR_S;
        end else if (eff_state == ERR_S) begin
            nxt_state = 4'd0;
        end else if (dir_q[0]) begin
            if (eff_state == MAX_S) begin
                nxt_state = 4'd0;
                wrap_c    = 1'b1;
            end else begin
                nxt_state = eff_state + 4'd1;
            end
        end else if (dir_q[1]) begin
            if (eff_state == 4'd0) begin
                nxt_state = MAX_S;
                wrap_c    = 1'b1;
            end else begin
                nxt_state = eff_state - 4'd1;
            end
        end
    end

    // Requests seen in STROBE are dropped: they are single-cycle pulses, and
    // only IDLE looks at them.
    always_comb begin
        fsm_d   = fsm_q;
        dir_d   = dir_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    fsm_d = ST_STROBE;
                    dir_d = req;
                end
            end
            ST_STROBE: begin
                fsm_d   = ST_IDLE;
                state_d = nxt_state;
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (Clear) begin
            fsm_d   = ST_IDLE;
            dir_d   = 2'b00;
            state_d = 4'd0;
        end
        error_d = (state_d == ERR_S);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            lvl_prev_q  <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            fsm_q       <= ST_IDLE;
            dir_q       <= '0;
            state_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lvl_q       <= lvl_d;
            lvl_prev_q  <= lvl_prev_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            fsm_q       <= fsm_d;
            dir_q       <= dir_d;
            state_q     <= state_d;
            error_q     <= error_d;
        end
    end

    // Strobes decode directly from the FSM register, so an async reset drops
    // them immediately.
    assign strobe = (fsm_q == ST_STROBE);
    assign Up     = strobe & dir_q[0];
    assign Down   = strobe & dir_q[1];
    assign wrap   = strobe & wrap_c;
    assign state  = state_q;
    assign error  = error_q;

endmodule

// File: tb/tb_updown_step_controller.sv
// Directed bench for updown_step_controller (DEBOUNCE_CYCLES=4, MAX_STATE=8).
// Observed vector layout: {Up, Down, wrap, error, state[3:0]}.
module tb_updown_step_controller;

    logic       Clock;
    logic       Reset_n;
    logic       Up_btn;
    logic       Down_btn;
    logic       Clear;
    logic       Up;
    logic       Down;
    logic [3:0] state;
    logic       wrap;
    logic       error;

    int n_assert = 0;
    int n_fail   = 0;

    updown_step_controller dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Up_btn   (Up_btn),
        .Down_btn (Down_btn),
        .Clear    (Clear),
        .Up       (Up),
        .Down     (Down),
        .state    (state),
        .wrap     (wrap),
        .error    (error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] vec();
        return {Up, Down, wrap, error, state};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (Up || Down) found = 1'b1;
        end
        chk({tag, " strobe seen"}, {7'd0, found}, 8'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit extra;
        extra = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (Up || Down) extra = 1'b1;
        end
        chk({tag, " no strobe"}, {7'd0, extra}, 8'd0);
    endtask

    task automatic press(input string tag, input logic u, input logic d,
                         input logic [7:0] exp_s, input logic [7:0] exp_n);
        Up_btn   = u;
        Down_btn = d;
        wait_strobe(tag);
        chk({tag, " strobe"}, vec(), exp_s);
        tick();
        chk({tag, " after"}, vec(), exp_n);
        Up_btn   = 1'b0;
        Down_btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int n_rep;
        int first_k;
        int second_k;

        Reset_n  = 1'b0;
        Up_btn   = 1'b0;
        Down_btn = 1'b0;
        Clear    = 1'b0;
        #12;
        chk("reset", vec(), 8'h00);
        @(negedge Clock);
        Reset_n = 1'b1;
        tick();
        tick();

        // Latency: raw high first sampled at edge 0, strobe after edge 6.
        Up_btn = 1'b1;
        repeat (6) tick();
        chk("latency edge5", vec(), 8'h00);
        tick();
        chk("latency strobe", vec(), 8'h80);
        tick();
        chk("latency after", vec(), 8'h01);
        quiet("held", 20);
        Up_btn = 1'b0;
        repeat (10) tick();

        // 3-cycle glitch is shorter than the debounce window.
        Up_btn = 1'b1;
        repeat (3) tick();
        Up_btn = 1'b0;
        quiet("glitch", 15);
        chk("glitch state", vec(), 8'h01);

        for (int s = 1; s < 8; s++) begin
            press("up step", 1'b1, 1'b0, 8'h80 | 8'(s), 8'(s + 1));
        end
        press("up wrap", 1'b1, 1'b0, 8'hA8, 8'h00);
        press("down wrap", 1'b0, 1'b1, 8'h60, 8'h08);
        press("both", 1'b1, 1'b1, 8'hC8, 8'h1F);
        press("down from err", 1'b0, 1'b1, 8'h5F, 8'h00);
        for (int s = 0; s < 3; s++) begin
            press("up to 3", 1'b1, 1'b0, 8'h80 | 8'(s), 8'(s + 1));
        end

        // Clear in the strobe cycle of an Up from 3.
        Up_btn = 1'b1;
        wait_strobe("clear");
        chk("clear strobe", vec(), 8'h83);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("clear result", vec(), 8'h00);
        quiet("clear held", 20);
        Up_btn = 1'b0;
        repeat (10) tick();
        press("post clear", 1'b1, 1'b0, 8'h80, 8'h01);

        // Async reset in the middle of a strobe.
        Up_btn = 1'b1;
        wait_strobe("mid reset");
        chk("mid reset strobe", vec(), 8'h81);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async reset", vec(), 8'h00);
        Up_btn = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        repeat (3) tick();
        chk("after reset", vec(), 8'h00);

        // Hold Up for 40 cycles after the first strobe.
        Up_btn = 1'b1;
        wait_strobe("hold");
        chk("hold first", vec(), 8'h80);
        n_rep    = 0;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (Up) begin
                n_rep++;
                if (n_rep == 1) first_k = k;
                if (n_rep == 2) second_k = k;
            end
        end
`ifdef UPDOWN_AUTO_REPEAT_EN
        chk("repeat count", 8'(n_rep), 8'd2);
        chk("repeat first", 8'(first_k), 8'd16);
        chk("repeat second", 8'(second_k), 8'd32);
        chk("repeat state", vec(), 8'h03);
`else
        chk("no repeat count", 8'(n_rep), 8'd0);
        chk("no repeat first", 8'(first_k), 8'd0);
        chk("no repeat state", vec(), 8'h01);
`endif
        Up_btn = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_step_controller.md
Name: updown_step_controller

Overview:
- Sequencing controller for the up/down Mealy display decoder.
- Synchronises and debounces the raw Up/Down pushbuttons, arbitrates between the two requesters, and owns the 4-bit state register the decoder reads.
- Emits single-cycle Up/Down strobes aligned with the pre-update state, so the decoder's Mealy output is valid for exactly one cycle per accepted press.
- States 0..MAX_STATE form a ring; state 15 is the error state.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a button level change (1..255)
MAX_STATE, 8, highest ring state; wrap point (1..14)
REPEAT_CYCLES, 16, auto-repeat period in cycles (used only with AUTO_REPEAT_EN; 2..255)

Ports:
Clock  input  1  single system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Up_btn  input  1  raw asynchronous Up pushbutton, active high
Down_btn  input  1  raw asynchronous Down pushbutton, active high
Clear  input  1  synchronous soft reset, active high
Up  output  1  one-cycle Up strobe to decoder
Down  output  1  one-cycle Down strobe to decoder
state  output  4  current state to decoder
wrap  output  1  one-cycle pulse when a step wraps MAX_STATE<->0
error  output  1  level, high while state==15

Behaviour:
- Reset (Reset_n low, async): state=0, Up=0, Down=0, wrap=0, error=0. Also clears synchronisers, debounce counters, debounced levels and the FSM.
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce: one 8-bit counter per button. It counts consecutive cycles in which the synchronised value differs from the debounced level, and resets to 0 on any agreeing sample. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Request: a rising edge of a debounced level is a request. Falling edges produce nothing.
- Latency: take the first edge sampling raw=1 as edge 0, with the button held stable. The strobe rises at edge 2+DEBOUNCE_CYCLES, is high for exactly one cycle, and state updates at the following edge.
- Controller FSM:
  - IDLE: waits for a request.
  - STROBE: one cycle. Drives Up or Down with the old state; commits the next state at the end of the cycle.
  - IDLE is re-entered afterwards.
  - Requests arriving during STROBE are dropped. Buttons must release and re-press.
- Arbitration:
  - Up request only: Up=1, Down=0.
  - Down request only: Down=1, Up=0.
  - Both requests in the same cycle: Up=1 and Down=1 for one cycle, then state=15.
- Next state:
  - Up: state+1, with MAX_STATE->0 (wrap=1 in the strobe cycle).
  - Down: state-1, with 0->MAX_STATE (wrap=1).
  - From 15: any single Up or Down goes to 0 (no wrap pulse). Both together stays at 15.
- error: registered, equals (state==15).
- Clear (synchronous, priority over requests):
  - Next cycle: state=0, Up=Down=0, wrap=0, FSM in IDLE.
  - Debounced levels retained, so a held button does not re-fire.
- Async reset mid-strobe: strobe drops immediately, state=0.
- State never holds values MAX_STATE+1..14. Those values are treated as 15 on the next strobe.

Optional Feature:
- Macro: UPDOWN_AUTO_REPEAT_EN.
- Defined: while exactly one debounced button stays high, an extra request of that direction is generated every REPEAT_CYCLES cycles after the initial strobe.
  - The repeat counter resets on release or when both buttons are high.
  - Both buttons high means no repeats.
- Undefined: one strobe per press only. Repeat counter and REPEAT_CYCLES logic are absent.

Test Plan:
- Reset then hold Up_btn=1 with DEBOUNCE_CYCLES=4 -> Up high for one cycle starting edge 6 with state=0; state=1 from edge 7; no further strobes while held.
- From state=8, press Up -> Up strobe with state=8, wrap=1, then state=0. From state=0, press Down -> Down strobe, wrap=1, then state=8.
- Up_btn glitch high for 3 cycles (DEBOUNCE_CYCLES=4) -> no strobe, state unchanged.
- Up_btn and Down_btn rise on the same edge -> Up=Down=1 for one cycle, then state=15 and error=1. Then press Down -> Down strobe with state=15, then state=0 and error=0.
- Clear asserted in the strobe cycle of an Up from state=3 -> state=0 the next cycle, no wrap. Reset_n pulsed low mid-sequence -> all outputs 0 immediately.
- With UPDOWN_AUTO_REPEAT_EN and REPEAT_CYCLES=16, hold Up for 40 cycles after the first strobe -> exactly 2 extra strobes, 16 cycles apart; state advances by 3 in total.
